shift_add_multiplier: RTL and testbench

//   Sequential unsigned N x N multiplier that drives one ripple_adder instance
//   as its partial-product accumulator. Each cycle it adds the multiplicand to
//   the upper product half when the current multiplier LSB is 1, then shifts

---
 rtl/shift_add_multiplier.sv | 125 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N shift-and-add multiplier built around a single
// N-bit ripple-carry adder; one product every N+1 cycles.

module ripple_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  output logic [WIDTH:0]   o_result
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign o_result[i]  = i_add1[i] ^ i_add2[i] ^ carry[i];
    assign carry[i + 1] = (i_add1[i] & i_add2[i]) | (carry[i] & (i_add1[i] ^ i_add2[i]));
  end

  // The carry out of the top bit becomes the MSB of the result.
  assign o_result[WIDTH] = carry[WIDTH];

endmodule

module shift_add_multiplier #(
  parameter int N = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [N-1:0]   i_multiplicand,
  input  logic [N-1:0]   i_multiplier,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*N-1:0] o_product
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    mcand;
  logic [N-1:0]    ph;
  logic [N-1:0]    pl;
  logic [CW-1:0]   count;
  logic [N:0]      add_result;
  logic [2*N-1:0]  shifted;
  logic            last_step;

  ripple_adder #(.WIDTH(N)) u_adder (
    .i_add1   (ph),
    .i_add2   (pl[0] ? mcand : '0),
    .o_result (add_result)
  );

  // {cout, sum} lands in PH, so the carry is never lost and no overflow is possible.
  assign shifted   = {add_result, pl[N-1:1]};
  assign last_step = (count == CW'(N - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) state_d = RUN;
      end
      RUN: begin
        o_busy = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = i_start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mcand     <= '0;
      ph        <= '0;
      pl        <= '0;
      count     <= '0;
      o_product <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (i_start) begin
            mcand <= i_multiplicand;
            pl    <= i_multiplier;
            ph    <= '0;
            count <= '0;
          end
        end
        RUN: begin
          {ph, pl} <= shifted;
          count    <= count + CW'(1);
          if (last_step) o_product <= shifted;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier at N=16, plus an
// exhaustive sweep of a second N=4 instance.

module tb_shift_add_multiplier;

  localparam int N  = 16;
  localparam int N4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  a = '0, b = '0;
  logic          busy, done;
  logic [2*N-1:0] prod;

  logic           start4 = 1'b0;
  logic [N4-1:0]  a4 = '0, b4 = '0;
  logic           busy4, done4;
  logic [2*N4-1:0] prod4;

  int n_checks = 0;
  int n_fail   = 0;

  shift_add_multiplier #(.N(N)) u_dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_multiplicand (a),
    .i_multiplier   (b),
    .o_busy         (busy),
    .o_done         (done),
    .o_product      (prod)
  );

  shift_add_multiplier #(.N(N4)) u_dut4 (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start4),
    .i_multiplicand (a4),
    .i_multiplier   (b4),
    .o_busy         (busy4),
    .o_done         (done4),
    .o_product      (prod4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: requests a multiply and follows it to o_done (bounded).
  // lat counts negedges from the request to the o_done sample; glitch > 0
  // pulses i_start with junk operands at that RUN cycle.
  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input int glitch,
                        output int lat, output int busy_n, output logic [2*N-1:0] prod_early);
    a = x; b = y; start = 1'b1;
    lat = 0; busy_n = 0; prod_early = '0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      a = N'($urandom);
      b = N'($urandom);
      if (lat == glitch) start = 1'b1;
      if (lat == 1) prod_early = prod;
      if (busy) busy_n++;
    end while (!done && lat < 100);
    start = 1'b0;
  endtask

  task automatic mul16(input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic [2*N-1:0] exp, input string tag, input int gap);
    int lat, busy_n;
    logic [2*N-1:0] pe;
    repeat (gap) @(negedge clk);
    run_op(x, y, -1, lat, busy_n, pe);
    check({tag, "_latency"}, 64'(lat), 64'(N + 1));
    check({tag, "_product"}, 64'(prod), 64'(exp));
  endtask

  task automatic run4(input logic [N4-1:0] x, input logic [N4-1:0] y);
    int lat;
    @(negedge clk);
    a4 = x; b4 = y; start4 = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start4 = 1'b0;
      a4 = ~x;
      b4 = ~y;
    end while (!done4 && lat < 50);
    check($sformatf("n4_lat_%0d_%0d", x, y), 64'(lat), 64'(N4 + 1));
    check($sformatf("n4_prod_%0d_%0d", x, y), 64'(prod4), 64'(8'(x) * 8'(y)));
  endtask

  initial begin
    int lat, busy_n, dones;
    logic [2*N-1:0] pe;
    logic [N-1:0] rx, ry;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", 64'(prod), 64'd0);
    check("rst_product_n4", 64'(prod4), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic 3*5 with busy profile
    run_op(16'd3, 16'd5, -1, lat, busy_n, pe);
    check("basic_latency", 64'(lat), 64'd17);
    check("basic_busy_cycles", 64'(busy_n), 64'd16);
    check("basic_busy_in_done", 64'(busy), 64'd0);
    check("basic_product", 64'(prod), 64'd15);
    @(negedge clk);
    check("basic_done_one_cycle", 64'(done), 64'd0);
    check("basic_product_held", 64'(prod), 64'd15);

    // Directed corner cases
    mul16(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "max", 1);
    mul16(16'h0000, 16'h1234, 32'h0000_0000, "zero_a", 1);
    mul16(16'h1234, 16'h0001, 32'h0000_1234, "ident_b", 1);
    mul16(16'h8000, 16'h0002, 32'h0001_0000, "msb_a", 2);
    mul16(16'hABCD, 16'h1234, 32'h0C37_4FA4, "mixed", 0);

    // Mid-RUN start pulse ignored, then back-to-back start during DONE
    @(negedge clk);
    run_op(16'h00FF, 16'h0101, 5, lat, busy_n, pe);
    check("glitch_latency", 64'(lat), 64'd17);
    check("glitch_product", 64'(prod), 64'h0000_FFFF);
    run_op(16'd7, 16'd9, -1, lat, busy_n, pe);
    check("b2b_product_held_in_run", 64'(pe), 64'h0000_FFFF);
    check("b2b_latency", 64'(lat), 64'd17);
    check("b2b_product", 64'(prod), 64'd63);

    // Reset at RUN cycle 8 aborts without a done pulse
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_abort_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", 64'(prod), 64'd0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    mul16(16'd6, 16'd7, 32'd42, "after_abort", 0);

    // Random pairs with idle gaps against an A*B model
    for (int i = 0; i < 100; i++) begin
      rx = N'($urandom);
      ry = N'($urandom);
      mul16(rx, ry, 32'(rx) * 32'(ry), $sformatf("rand%0d", i), int'($urandom_range(3, 0)));
    end

    // Exhaustive N=4
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run4(N4'(x), N4'(y));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
